// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code counter slice.
package gray_pkg;

  // Default code width when the instantiating level does not override it.
  localparam int GRAY_WIDTH_DEFAULT = 8;

  // Output-side handshake state: IDLE has no code on offer, VALID holds one.
  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

endpackage : gray_pkg

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray conversion, one XOR level deep.
module binary_to_gray #(
  parameter int WIDTH = gray_pkg::GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of adjacent binary bits; the top bit passes through.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule : binary_to_gray

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code output and a
// valid/ready handshake towards a downstream Gray-to-binary stage.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_code,
  output logic             gray_valid,
  input  logic             gray_ready,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;
  logic             update_slot;

  // A new value may be taken when nothing is on offer or the offer is consumed.
  assign update_slot = (state == IDLE) || gray_ready;

  // Next binary count and boundary detection; loads never flag a wrap.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the if/else leaves it unassigned and infers a latch.
    count_next = count;
    wrap_next  = 1'b0;
    if (update_slot) begin
      if (load) begin
        count_next = load_bin;
      end else if (en) begin
        if (up_dn) begin
          count_next = count + ONE;
          wrap_next  = (count == ALL_ONE);
        end else begin
          count_next = count - ONE;
          wrap_next  = (count == '0);
        end
      end
    end
  end

  binary_to_gray #(.WIDTH(WIDTH)) u_b2g (
    .bin  (count_next),
    .gray (gray_next)
  );

  // State register: reset lands in IDLE with nothing on offer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: any step or load offers a code; an empty slot retires it.
  always_comb begin
    state_next = state;
    if (update_slot) begin
      state_next = (load || en) ? VALID : IDLE;
    end
  end

  // Output decode: valid comes straight from the state flop, so it cannot glitch.
  always_comb begin
    gray_valid = (state == VALID);
  end

  // Datapath registers: count, presented Gray code and the one-cycle wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      gray_code <= '0;
      wrap      <= 1'b0;
    end else begin
      count     <= count_next;
      gray_code <= gray_next;
      wrap      <= wrap_next;
    end
  end

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: a reference model pushes the expected
// outputs for every driven cycle, and they are popped and compared after the edge.
module tb_gray_counter;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] gray;
    logic         valid;
    logic         wrap;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up_dn, load, gray_ready;
  logic [W-1:0] load_bin;
  logic [W-1:0] gray_code;
  logic         gray_valid, wrap;

  int checks   = 0;
  int failures = 0;

  exp_t         sb_q[$];
  logic [W-1:0] m_count;
  logic         m_valid;
  logic         m_wrap;

  gray_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_dn      (up_dn),
    .load       (load),
    .load_bin   (load_bin),
    .gray_code  (gray_code),
    .gray_valid (gray_valid),
    .gray_ready (gray_ready),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one cycle of stimulus (called just after a falling edge), advance the
  // model, push its prediction, then pop and compare after the next falling edge.
  task automatic cycle(input logic i_en, input logic i_up, input logic i_load,
                       input logic [W-1:0] i_bin, input logic i_ready);
    exp_t e, got;
    logic slot;
    en = i_en; up_dn = i_up; load = i_load; load_bin = i_bin; gray_ready = i_ready;
    slot   = !m_valid || i_ready;
    m_wrap = 1'b0;
    if (slot) begin
      if (i_load) begin
        m_count = i_bin;
        m_valid = 1'b1;
      end else if (i_en) begin
        if (i_up) begin
          m_wrap  = (m_count == 8'hFF);
          m_count = m_count + 8'd1;
        end else begin
          m_wrap  = (m_count == 8'h00);
          m_count = m_count - 8'd1;
        end
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    e.gray = to_gray(m_count); e.valid = m_valid; e.wrap = m_wrap;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb_q.pop_front();
    check("gray_code", 32'(gray_code), 32'(got.gray));
    check("gray_valid", 32'(gray_valid), 32'(got.valid));
    check("wrap", 32'(wrap), 32'(got.wrap));
  endtask

  initial begin
    logic [W-1:0] prev;
    int wraps;
    rst = 1'b1; en = 0; up_dn = 1; load = 0; load_bin = '0; gray_ready = 0;
    m_count = '0; m_valid = 0; m_wrap = 0;
    @(negedge clk); @(negedge clk);
    check("reset_gray", 32'(gray_code), 32'h0);
    check("reset_valid", 32'(gray_valid), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Idle with nothing requested stays empty.
    cycle(0, 1, 0, 8'h00, 0);

    // Load 0x80 from IDLE presents Gray 0xC0 without wrap.
    cycle(0, 1, 1, 8'h80, 0);
    check("load_gray_c0", 32'(gray_code), 32'hC0);
    check("load_wrap", 32'(wrap), 32'h0);

    // Reset asserted mid-VALID clears outputs immediately, ignores en/load.
    #2 rst = 1'b1;
    #1;
    check("rst_async_gray", 32'(gray_code), 32'h0);
    check("rst_async_valid", 32'(gray_valid), 32'h0);
    check("rst_async_wrap", 32'(wrap), 32'h0);
    en = 1; load = 1; load_bin = 8'h33; gray_ready = 1;
    @(negedge clk);
    check("rst_hold_gray", 32'(gray_code), 32'h0);
    check("rst_hold_valid", 32'(gray_valid), 32'h0);
    en = 0; load = 0;
    rst = 1'b0;
    m_count = '0; m_valid = 0; m_wrap = 0; sb_q.delete();
    #2;
    check("rst_release_gray", 32'(gray_code), 32'h0);
    check("rst_release_valid", 32'(gray_valid), 32'h0);
    @(negedge clk);

    // Up wrap: 0xFF -> 0x00 with a single-cycle wrap pulse.
    cycle(0, 1, 1, 8'hFF, 1);
    check("pre_upwrap_gray", 32'(gray_code), 32'h80);
    cycle(1, 1, 0, 8'h00, 1);
    check("upwrap_gray", 32'(gray_code), 32'h00);
    check("upwrap_pulse", 32'(wrap), 32'h1);
    cycle(0, 1, 0, 8'h00, 1);
    check("upwrap_drop", 32'(wrap), 32'h0);

    // Down wrap: 0x00 -> 0xFF (Gray 0x80).
    cycle(1, 0, 0, 8'h00, 1);
    check("dnwrap_gray", 32'(gray_code), 32'h80);
    check("dnwrap_pulse", 32'(wrap), 32'h1);
    cycle(1, 0, 0, 8'h00, 1);
    check("dn_step_nowrap", 32'(wrap), 32'h0);

    // Load must win over en and never flag a wrap, even from the boundary.
    cycle(1, 1, 1, 8'h00, 1);
    cycle(1, 1, 1, 8'hFF, 1);
    cycle(1, 1, 1, 8'h00, 1);
    check("load_no_wrap", 32'(wrap), 32'h0);

    // Backpressure: code 0x07 held for 4 stalled cycles, then steps to 0x05.
    cycle(0, 1, 1, 8'h05, 1);
    check("bp_start", 32'(gray_code), 32'h07);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, (i == 2), 8'h40, 0);
      check("bp_hold", 32'(gray_code), 32'h07);
    end
    cycle(1, 1, 0, 8'h00, 1);
    check("bp_release", 32'(gray_code), 32'h05);
    cycle(0, 1, 0, 8'h00, 1);
    check("bp_retire_valid", 32'(gray_valid), 32'h0);

    // A handful of random mixed cycles against the model.
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(7) == 0),
            8'($urandom), 1'($urandom_range(1)));

    // Sweep: 512 up steps, one-bit transitions, decode matches, two wraps.
    cycle(0, 1, 1, 8'h00, 1);
    prev  = gray_code;
    wraps = 0;
    for (int i = 0; i < 512; i++) begin
      cycle(1, 1, 0, 8'h00, 1);
      check("sweep_onebit", 32'($countones(gray_code ^ prev)), 32'd1);
      check("sweep_decode", 32'(to_bin(gray_code)), 32'(m_count));
      if (wrap) wraps++;
      prev = gray_code;
    end
    check("sweep_wraps", 32'(wraps), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gray_counter
